// File: rtl/uart_pkg.sv
// ============================================================
// Package : uart_pkg
// Purpose : shared FSM encoding and baud/timeout constants for the UART TX path
// Rev     : 1.0
// ============================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_WAIT = 3'd2,
    ST_GAP  = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  // Baud select codes understood by uart_tx_byte
  localparam logic [2:0] c_baud_9600   = 3'd0;
  localparam logic [2:0] c_baud_19200  = 3'd1;
  localparam logic [2:0] c_baud_38400  = 3'd2;
  localparam logic [2:0] c_baud_57600  = 3'd3;
  localparam logic [2:0] c_baud_115200 = 3'd4;

  // One byte at 9600 baud from a 50 MHz clock, with margin
  localparam int c_timeout_default = 60000;

endpackage

`default_nettype wire

// File: rtl/uart_rr_arb2.sv
// ============================================================
// Module  : uart_rr_arb2
// Purpose : two-way round-robin pick; pointer moves away from the served side
// Rev     : 1.0
// ============================================================
`default_nettype none

module uart_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_valid,
  input  logic       i_update,
  input  logic       i_served,
  output logic       o_pick,
  output logic       o_pick_valid
);

  logic r_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (i_update) begin
      r_ptr <= ~i_served;
    end
  end

  // Pointer only breaks ties; a lone requester always wins
  always_comb begin
    o_pick_valid = |i_valid;
    o_pick       = r_ptr;
    if (i_valid == 2'b01) begin
      o_pick = 1'b0;
    end else if (i_valid == 2'b10) begin
      o_pick = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================
// Module  : uart_tx_arbiter
// Purpose : grants one uart_tx_byte to two requesters, one packet at a time
// Rev     : 1.0
// ============================================================
`default_nettype none

module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int         LEN_W          = 4,
  parameter int         GAP_CYCLES     = 2,
  parameter int         TIMEOUT_CYCLES = c_timeout_default,
  parameter logic [2:0] BAUD_SEL       = c_baud_9600
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Req0,
  input  logic             Req1,
  input  logic [LEN_W-1:0] Len0,
  input  logic [LEN_W-1:0] Len1,
  input  logic [7:0]       Data0,
  input  logic [7:0]       Data1,
  output logic             Rd0,
  output logic             Rd1,
  output logic             Grant0,
  output logic             Grant1,
  output logic             Done0,
  output logic             Done1,
  output logic             Err0,
  output logic             Err1,
  output logic             Tx_en,
  output logic [7:0]       Tx_data,
  output logic [2:0]       Tx_baud_sel,
  input  logic             Tx_done
);

  localparam int c_TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_GAP_W = $clog2(GAP_CYCLES + 2);
  localparam logic [c_TMR_W-1:0] c_tmr_last = c_TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_GAP_W-1:0] c_gap_last =
    (GAP_CYCLES > 0) ? c_GAP_W'(GAP_CYCLES - 1) : '0;

  state_t             r_state;
  state_t             w_next;
  logic               r_idx;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_cnt;
  logic [c_TMR_W-1:0] r_tmr;
  logic [c_GAP_W-1:0] r_gap;
  logic               r_err;
  logic [7:0]         r_tx_data;

  logic [1:0] w_valid;
  logic       w_pick;
  logic       w_pick_valid;
  logic       w_fin;
  logic       w_send;
  logic       w_active;
  logic       w_timeout;
  logic [7:0] w_data_sel;

  assign w_valid    = {Req1 & (Len1 != '0), Req0 & (Len0 != '0)};
  assign w_fin      = (r_state == ST_FIN);
  assign w_send     = (r_state == ST_SEND);
  assign w_active   = (r_state != ST_IDLE);
  assign w_data_sel = r_idx ? Data1 : Data0;
  assign w_timeout  = ~Tx_done & (r_tmr == c_tmr_last);

  uart_rr_arb2 u_arb (
    .clk         (Clk),
    .rst_n       (Rst_n),
    .i_valid     (w_valid),
    .i_update    (w_fin),
    .i_served    (r_idx),
    .o_pick      (w_pick),
    .o_pick_valid(w_pick_valid)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A Tx_done arriving on the timeout clock takes the done path
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_pick_valid) w_next = ST_SEND;
      ST_SEND: w_next = ST_WAIT;
      ST_WAIT: begin
        if (Tx_done) begin
          if (r_cnt == r_len)       w_next = ST_FIN;
          else if (GAP_CYCLES == 0) w_next = ST_SEND;
          else                      w_next = ST_GAP;
        end else if (w_timeout) begin
          w_next = ST_FIN;
        end
      end
      ST_GAP:  if (r_gap == c_gap_last) w_next = ST_SEND;
      ST_FIN:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_idx     <= 1'b0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_tmr     <= '0;
      r_gap     <= '0;
      r_err     <= 1'b0;
      r_tx_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_idx <= w_pick;
            r_len <= w_pick ? Len1 : Len0;
            r_cnt <= '0;
          end
        end
        ST_SEND: begin
          r_cnt     <= r_cnt + 1'b1;
          r_tmr     <= '0;
          r_err     <= 1'b0;
          r_tx_data <= w_data_sel;
        end
        ST_WAIT: begin
          r_tmr <= r_tmr + 1'b1;
          r_gap <= '0;
          r_err <= w_timeout;
        end
        ST_GAP:  r_gap <= r_gap + 1'b1;
        default: ;
      endcase
    end
  end

  // Tx_data follows the requester during SEND so it is valid alongside Tx_en
  assign Tx_en       = w_send;
  assign Tx_data     = w_send ? w_data_sel : r_tx_data;
  assign Tx_baud_sel = BAUD_SEL;
  assign Rd0         = w_send & ~r_idx;
  assign Rd1         = w_send & r_idx;
  assign Grant0      = w_active & ~r_idx;
  assign Grant1      = w_active & r_idx;
  assign Done0       = w_fin & ~r_err & ~r_idx;
  assign Done1       = w_fin & ~r_err & r_idx;
  assign Err0        = w_fin & r_err & ~r_idx;
  assign Err1        = w_fin & r_err & r_idx;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================
// Module  : tb_uart_tx_arbiter
// Purpose : directed self-checking bench for uart_tx_arbiter
// Rev     : 1.0
// ============================================================
`default_nettype none

module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] len0 = '0, len1 = '0;
  logic [7:0] data0 = '0, data1 = '0;
  logic       rd0, rd1, grant0, grant1, done0, done1, err0, err1, tx_en;
  logic [7:0] tx_data;
  logic [2:0] tx_baud_sel;
  logic       tx_done = 1'b0;

  logic       b_req0 = 1'b0;
  logic [3:0] b_len0 = '0;
  logic [7:0] b_data0 = '0;
  logic       b_rd0, b_rd1, b_grant0, b_grant1, b_done0, b_done1, b_err0, b_err1, b_tx_en;
  logic [7:0] b_tx_data;
  logic [2:0] b_tx_baud_sel;
  logic       b_tx_done = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.LEN_W(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(50), .BAUD_SEL(3'd5)) u_dut (
    .Clk(clk), .Rst_n(rst_n), .Req0(req0), .Req1(req1), .Len0(len0), .Len1(len1),
    .Data0(data0), .Data1(data1), .Rd0(rd0), .Rd1(rd1), .Grant0(grant0), .Grant1(grant1),
    .Done0(done0), .Done1(done1), .Err0(err0), .Err1(err1), .Tx_en(tx_en),
    .Tx_data(tx_data), .Tx_baud_sel(tx_baud_sel), .Tx_done(tx_done)
  );

  uart_tx_arbiter #(.LEN_W(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(200), .BAUD_SEL(3'd0)) u_dut_b (
    .Clk(clk), .Rst_n(rst_n), .Req0(b_req0), .Req1(1'b0), .Len0(b_len0), .Len1(4'd0),
    .Data0(b_data0), .Data1(8'd0), .Rd0(b_rd0), .Rd1(b_rd1), .Grant0(b_grant0), .Grant1(b_grant1),
    .Done0(b_done0), .Done1(b_done1), .Err0(b_err0), .Err1(b_err1), .Tx_en(b_tx_en),
    .Tx_data(b_tx_data), .Tx_baud_sel(b_tx_baud_sel), .Tx_done(b_tx_done)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] bytes0 [16];
  logic [7:0] bytes1 [16];
  int ptr0, ptr1;
  bit pend0, pend1;
  int done_dly, tx_delay;
  bit tx_auto;
  int cyc_no;
  int n_en, n_rd0, n_done0, n_done1, n_err0, n_err1;
  int done0_cyc, done1_cyc, err0_cyc;
  bit prev_g0, prev_g1, both_g, strobe_bad;
  logic [7:0] en_data[$];
  int en_cyc[$];
  int txd_cyc[$];
  int grant_order[$];

  task automatic clear_log();
    n_en = 0; n_rd0 = 0; n_done0 = 0; n_done1 = 0; n_err0 = 0; n_err1 = 0;
    done0_cyc = -1; done1_cyc = -1; err0_cyc = -1;
    both_g = 0; strobe_bad = 0;
    en_data.delete(); en_cyc.delete(); txd_cyc.delete(); grant_order.delete();
  endtask

  // One clock of bench time: sample DUT A, then play requester and uart_tx_byte
  task automatic cyc();
    bit saw_en;
    @(posedge clk); #1;
    cyc_no++;
    saw_en = tx_en;
    if (tx_en) begin n_en++; en_data.push_back(tx_data); en_cyc.push_back(cyc_no); end
    if ((rd0 | rd1) !== tx_en || (rd0 & ~grant0) || (rd1 & ~grant1)) strobe_bad = 1;
    if (grant0 & grant1) both_g = 1;
    if (grant0 && !prev_g0) grant_order.push_back(0);
    if (grant1 && !prev_g1) grant_order.push_back(1);
    prev_g0 = grant0; prev_g1 = grant1;
    if (done0) begin n_done0++; done0_cyc = cyc_no; end
    if (done1) begin n_done1++; done1_cyc = cyc_no; end
    if (err0) begin n_err0++; err0_cyc = cyc_no; end
    if (err1) n_err1++;
    if (pend0) begin ptr0++; data0 = bytes0[ptr0 % 16]; pend0 = 0; end
    if (pend1) begin ptr1++; data1 = bytes1[ptr1 % 16]; pend1 = 0; end
    if (rd0) begin n_rd0++; pend0 = 1; end
    if (rd1) pend1 = 1;
    tx_done = 1'b0;
    if (done_dly > 0) begin
      done_dly--;
      if (done_dly == 0) begin tx_done = 1'b1; txd_cyc.push_back(cyc_no); end
    end
    if (saw_en && tx_auto) done_dly = tx_delay;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; done_dly = 0; tx_done = 1'b0;
    req0 = 0; req1 = 0; pend0 = 0; pend1 = 0;
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    cyc_no = 0; tx_auto = 1; tx_delay = 20; done_dly = 0;
    prev_g0 = 0; prev_g1 = 0; pend0 = 0; pend1 = 0;
    clear_log();
    rst_n = 1'b0;
    cyc();
    checks++;
    if ({grant0, grant1, rd0, rd1, done0, done1, err0, err1, tx_en, tx_data} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0",
               {grant0, grant1, rd0, rd1, done0, done1, err0, err1, tx_en, tx_data});
    end
    checks++;
    if (tx_baud_sel !== 3'd5) begin errors++; $display("FAIL baud_sel got=%0d exp=5", tx_baud_sel); end
    rst_n = 1'b1;
    cyc(); cyc();
    checks++;
    if ({grant0, grant1, tx_en} !== 3'd0) begin
      errors++; $display("FAIL idle_after_reset got=%b exp=000", {grant0, grant1, tx_en});
    end
  endtask

  task automatic test_single_packet();
    int c_g;
    clear_log();
    bytes0[0] = 8'h41; bytes0[1] = 8'h42; bytes0[2] = 8'h43;
    ptr0 = 0; data0 = bytes0[0]; len0 = 4'd3; req0 = 1; tx_delay = 20; tx_auto = 1;
    c_g = -1;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (grant0 && c_g < 0) begin c_g = cyc_no; req0 = 0; end
      if (n_done0 > 0) break;
    end
    checks++;
    if (n_done0 != 1) begin errors++; $display("FAIL single_done got=%0d exp=1", n_done0); end
    checks++;
    if (n_en != 3 || n_rd0 != 3) begin
      errors++; $display("FAIL single_counts got en=%0d rd=%0d exp en=3 rd=3", n_en, n_rd0);
    end
    checks++;
    if ({en_data[0], en_data[1], en_data[2]} !== 24'h414243) begin
      errors++; $display("FAIL single_data got=%h exp=414243", {en_data[0], en_data[1], en_data[2]});
    end
    checks++;
    if (en_cyc[0] != c_g) begin
      errors++; $display("FAIL grant_with_first_en got=%0d exp=%0d", en_cyc[0], c_g);
    end
    checks++;
    if (en_cyc[1] - txd_cyc[0] != 3 || en_cyc[2] - txd_cyc[1] != 3) begin
      errors++; $display("FAIL gap_spacing got=%0d,%0d exp=3,3",
                         en_cyc[1] - txd_cyc[0], en_cyc[2] - txd_cyc[1]);
    end
    checks++;
    if (done0_cyc != txd_cyc[2] + 1 || grant0 !== 1'b1) begin
      errors++; $display("FAIL done_timing got cyc=%0d grant0=%b exp cyc=%0d grant0=1",
                         done0_cyc, grant0, txd_cyc[2] + 1);
    end
    cyc(); cyc();
    checks++;
    if (grant0 !== 1'b0 || tx_data !== 8'h43) begin
      errors++; $display("FAIL post_packet got grant0=%b data=%h exp grant0=0 data=43", grant0, tx_data);
    end
    checks++;
    if (grant_order.size() != 1 || grant_order[0] != 0 || both_g || strobe_bad) begin
      errors++; $display("FAIL single_grant got n=%0d both=%0d strobe=%0d exp n=1 both=0 strobe=0",
                         grant_order.size(), both_g, strobe_bad);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] ord;
    do_reset();
    clear_log();
    bytes0[0] = 8'hA0; bytes0[1] = 8'hA1; bytes1[0] = 8'hB0; bytes1[1] = 8'hB1;
    ptr0 = 0; ptr1 = 0; data0 = bytes0[0]; data1 = bytes1[0];
    len0 = 4'd1; len1 = 4'd1; req0 = 1; req1 = 1; tx_delay = 3;
    for (int i = 0; i < 400; i++) begin
      cyc();
      if (n_done0 + n_done1 >= 4) break;
    end
    req0 = 0; req1 = 0;
    cyc(); cyc(); cyc();
    ord = '1;
    for (int i = 0; i < 4 && i < grant_order.size(); i++) ord[i] = grant_order[i][0];
    checks++;
    if (grant_order.size() != 4 || ord !== 4'b1010) begin
      errors++; $display("FAIL rr_order got n=%0d ord=%b exp n=4 ord=1010", grant_order.size(), ord);
    end
    checks++;
    if ({en_data[0], en_data[1], en_data[2], en_data[3]} !== 32'hA0B0A1B1) begin
      errors++; $display("FAIL rr_data got=%h exp=a0b0a1b1",
                         {en_data[0], en_data[1], en_data[2], en_data[3]});
    end
    checks++;
    if (both_g || strobe_bad) begin
      errors++; $display("FAIL rr_exclusive got both=%0d strobe=%0d exp 0 0", both_g, strobe_bad);
    end
  endtask

  task automatic test_len_zero();
    clear_log();
    bytes0[0] = 8'h11; bytes0[1] = 8'h22; ptr0 = 0; data0 = bytes0[0];
    len1 = 4'd0; req1 = 1; len0 = 4'd2; req0 = 1; tx_delay = 5;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (grant0) req0 = 0;
      if (n_done0 > 0) break;
    end
    for (int i = 0; i < 10; i++) cyc();
    req1 = 0;
    checks++;
    if (n_done0 != 1 || n_en != 2) begin
      errors++; $display("FAIL len0_packet got done=%0d en=%0d exp done=1 en=2", n_done0, n_en);
    end
    checks++;
    if (grant_order.size() != 1 || grant_order[0] != 0) begin
      errors++; $display("FAIL len_zero_ignored got grants=%0d exp=1 (req0 only)", grant_order.size());
    end
  endtask

  task automatic test_timeout();
    clear_log();
    bytes0[0] = 8'h71; ptr0 = 0; data0 = bytes0[0];
    bytes1[0] = 8'h81; ptr1 = 0; data1 = bytes1[0];
    tx_auto = 0; tx_delay = 4; len0 = 4'd2; req0 = 1;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (grant0 && req0) begin req0 = 0; len1 = 4'd1; req1 = 1; end
      if (n_err0 > 0) break;
    end
    checks++;
    if (n_err0 != 1 || err0_cyc - en_cyc[0] != 51) begin
      errors++; $display("FAIL timeout_err got n=%0d dist=%0d exp n=1 dist=51", n_err0, err0_cyc - en_cyc[0]);
    end
    checks++;
    if (n_done0 != 0 || grant0 !== 1'b1) begin
      errors++; $display("FAIL timeout_fin got done=%0d grant0=%b exp done=0 grant0=1", n_done0, grant0);
    end
    tx_auto = 1;
    cyc();
    checks++;
    if (grant0 !== 1'b0 || grant1 !== 1'b0) begin
      errors++; $display("FAIL timeout_release got g0=%b g1=%b exp 0 0", grant0, grant1);
    end
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (grant1) req1 = 0;
      if (n_done1 > 0) break;
    end
    checks++;
    if (n_done1 != 1 || n_en != 2 || en_data[1] !== 8'h81) begin
      errors++; $display("FAIL pending_req1 got done1=%0d en=%0d data=%h exp 1 2 81", n_done1, n_en, en_data[1]);
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    bytes0[0] = 8'h51; bytes0[1] = 8'h52; bytes0[2] = 8'h53;
    ptr0 = 0; data0 = bytes0[0]; len0 = 4'd3; req0 = 1; tx_delay = 20; tx_auto = 1;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (grant0) req0 = 0;
      if (n_en >= 2) break;
    end
    for (int i = 0; i < 5; i++) cyc();
    rst_n = 1'b0; done_dly = 0; tx_done = 1'b0;
    cyc();
    checks++;
    if ({grant0, grant1, rd0, rd1, done0, done1, err0, err1, tx_en, tx_data} !== 17'd0) begin
      errors++; $display("FAIL midreset_outputs got=%h exp=0",
                         {grant0, grant1, rd0, rd1, done0, done1, err0, err1, tx_en, tx_data});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) cyc();
    checks++;
    if (n_done0 != 0 || n_err0 != 0 || grant0 !== 1'b0) begin
      errors++; $display("FAIL midreset_quiet got done=%0d err=%0d g0=%b exp 0 0 0", n_done0, n_err0, grant0);
    end
    ptr0 = 0; pend0 = 0; data0 = bytes0[0]; len0 = 4'd2; req0 = 1; tx_delay = 6;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (grant0) req0 = 0;
      if (n_done0 > 0) break;
    end
    checks++;
    if (n_done0 != 1 || n_en != 4 || {en_data[2], en_data[3]} !== 16'h5152) begin
      errors++; $display("FAIL midreset_restart got done=%0d en=%0d data=%h exp 1 4 5152",
                         n_done0, n_en, {en_data[2], en_data[3]});
    end
  endtask

  task automatic test_len15_nogap();
    int k, bcyc, last_txd, bdly, done_at, data_bad, gap_bad;
    bit bpend, other_bad;
    k = 0; bcyc = 0; last_txd = -100; bdly = 0; done_at = -1;
    data_bad = 0; gap_bad = 0; bpend = 0; other_bad = 0;
    b_data0 = 8'd0; b_len0 = 4'd15; b_req0 = 1;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      bcyc++;
      if (b_tx_en) begin
        if (b_tx_data !== 8'(k)) data_bad++;
        if (k > 0 && bcyc != last_txd + 1) gap_bad++;
        k++;
      end
      if (b_grant0) b_req0 = 0;
      if (b_done0) done_at = bcyc;
      if (b_grant1 | b_rd1 | b_done1 | b_err1 | b_err0) other_bad = 1;
      if (bpend) begin b_data0 = b_data0 + 8'd1; bpend = 0; end
      if (b_rd0) bpend = 1;
      b_tx_done = 1'b0;
      if (bdly > 0) begin
        bdly--;
        if (bdly == 0) begin b_tx_done = 1'b1; last_txd = bcyc; end
      end
      if (b_tx_en) bdly = 4;
      if (done_at >= 0) break;
    end
    checks++;
    if (k != 15 || data_bad != 0) begin
      errors++; $display("FAIL len15_bytes got n=%0d bad_data=%0d exp n=15 bad_data=0", k, data_bad);
    end
    checks++;
    if (gap_bad != 0) begin errors++; $display("FAIL len15_nogap got late=%0d exp=0", gap_bad); end
    checks++;
    if (done_at != last_txd + 1) begin
      errors++; $display("FAIL len15_done got=%0d exp=%0d", done_at, last_txd + 1);
    end
    checks++;
    if (other_bad || b_tx_baud_sel !== 3'd0) begin
      errors++; $display("FAIL len15_side got other=%0d baud=%0d exp 0 0", other_bad, b_tx_baud_sel);
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_len_zero();
    test_timeout();
    test_reset_mid();
    test_len15_nogap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
